vedic_mult_pipe: RTL

//  Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier, WIDTH x WIDTH -> 2*WIDTH.

---
 rtl/vedic_mult_pipe_if.sv | 27 ++
 rtl/vedic_mult_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vedic_mult_pipe_if.sv
// Handshake bundle for vedic_mult_pipe.
//   master: operand producer / result consumer (drives in_valid, signed_mode, a, b, out_ready)
//   slave : the multiplier (drives in_ready, out_valid, product, out_signed)
// WIDTH is the operand width; product is 2*WIDTH bits.
interface vedic_mult_pipe_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 out_signed;

  modport master (
    output in_valid, signed_mode, a, b, out_ready,
    input  in_ready, out_valid, product, out_signed
  );

  modport slave (
    input  in_valid, signed_mode, a, b, out_ready,
    output in_ready, out_valid, product, out_signed
  );
endinterface

// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam (Vedic) multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Operands are reduced to magnitudes + sign in stage 0, multiplied by recursive
// quadrant decomposition down to 2x2 Vedic cells, and the sign is re-applied in
// the output register. Latency is log2(WIDTH) cycles; one result per cycle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  vedic_mult_pipe_if.slave: in_valid/in_ready/signed_mode/a/b on the
//        input side, out_valid/out_ready/product/out_signed on the output side.
// Backpressure is a single global enable: when the output holds an unaccepted
// result every register in the pipe holds.
module vedic_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  vedic_mult_pipe_if.slave  bus
);
  localparam int LATENCY = $clog2(WIDTH);
  // Registers carrying a valid bit before the output register: stage 0 plus
  // one per intermediate recursion level.
  localparam int NS = LATENCY - 1;

  if (WIDTH < 4 || WIDTH > 32 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("vedic_mult_pipe: WIDTH must be a power of 2 in 4..32");
  end

  logic en;
  logic out_valid_reg;
  logic out_signed_reg;
  logic [2*WIDTH-1:0] product_reg;

  // Stall only when a result is sitting unaccepted at the output.
  assign en = !(out_valid_reg && !bus.out_ready);
  assign bus.in_ready   = en;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_signed = out_signed_reg;
  assign bus.product    = product_reg;

  // ---------------- control shift chain (valid / neg / signed) ----------------
  logic [NS-1:0] vld_reg, vld_next;
  logic [NS-1:0] neg_reg, neg_next;
  logic [NS-1:0] sgn_reg, sgn_next;

  always_comb begin
    vld_next = vld_reg;
    neg_next = neg_reg;
    sgn_next = sgn_reg;
    vld_next[0] = bus.in_valid;
    neg_next[0] = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    sgn_next[0] = bus.signed_mode;
    for (int i = 1; i < NS; i++) begin
      vld_next[i] = vld_reg[i-1];
      neg_next[i] = neg_reg[i-1];
      sgn_next[i] = sgn_reg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
      neg_reg <= '0;
      sgn_reg <= '0;
    end else if (en) begin
      vld_reg <= vld_next;
      neg_reg <= neg_next;
      sgn_reg <= sgn_next;
    end
  end

  // ---------------- stage 0: magnitudes ----------------
  // -(-2^(W-1)) wraps back to 2^(W-1), which is exactly the right magnitude
  // when read as unsigned, so no extra bit is needed.
  logic [WIDTH-1:0] mag_a_reg, mag_a_next;
  logic [WIDTH-1:0] mag_b_reg, mag_b_next;

  always_comb begin
    mag_a_next = bus.a;
    mag_b_next = bus.b;
    if (bus.signed_mode && bus.a[WIDTH-1]) mag_a_next = -bus.a;
    if (bus.signed_mode && bus.b[WIDTH-1]) mag_b_next = -bus.b;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mag_a_reg <= mag_a_next;
      mag_b_reg <= mag_b_next;
    end
  end

  // ---------------- recursion levels ----------------
  // Level gi produces every partial product of an S-bit chunk of |a| with an
  // S-bit chunk of |b| (S = 2^gi). p_src is what level gi+1 consumes: level 1
  // (2x2 cells) feeds level 2 combinationally, levels 2..LATENCY-1 are
  // registered, and the last level feeds the negate/output register directly.
  for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_lvl
    localparam int S  = 1 << gi;
    localparam int H  = S / 2;
    localparam int N  = WIDTH / S;
    localparam int PW = 2 * S;

    logic [PW-1:0] p_next [N][N];
    logic [PW-1:0] p_src  [N][N];

    if (gi == 1) begin : g_cell
      // 2x2 vertical-and-crosswise: bit0 = a0b0, middle = a1b0 + a0b1, top = a1b1.
      always_comb begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            p_next[i][j] = PW'(mag_a_reg[2*i] & mag_b_reg[2*j])
                         + (PW'({1'b0, mag_a_reg[2*i+1] & mag_b_reg[2*j]}
                              + {1'b0, mag_a_reg[2*i] & mag_b_reg[2*j+1]}) << 1)
                         + (PW'(mag_a_reg[2*i+1] & mag_b_reg[2*j+1]) << 2);
          end
        end
      end
    end else begin : g_comb
      // Quadrants of chunk pair (i,j): q0=lo*lo, q1/q2=cross, q3=hi*hi.
      always_comb begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            p_next[i][j] = PW'(g_lvl[gi-1].p_src[2*i][2*j])
                         + (PW'({1'b0, g_lvl[gi-1].p_src[2*i+1][2*j]}
                              + {1'b0, g_lvl[gi-1].p_src[2*i][2*j+1]}) << H)
                         + (PW'(g_lvl[gi-1].p_src[2*i+1][2*j+1]) << S);
          end
        end
      end
    end

    if (gi == 1 || gi == LATENCY) begin : g_pass
      assign p_src = p_next;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (en) p_src <= p_next;
      end
    end
  end

  // ---------------- output: re-apply sign ----------------
  logic [2*WIDTH-1:0] mag_prod;
  logic [2*WIDTH-1:0] product_next;

  assign mag_prod     = g_lvl[LATENCY].p_src[0][0];
  assign product_next = neg_reg[NS-1] ? -mag_prod : mag_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_signed_reg <= 1'b0;
      product_reg    <= '0;
    end else if (en) begin
      out_valid_reg <= vld_reg[NS-1];
      // Bubbles leave product/out_signed untouched.
      if (vld_reg[NS-1]) begin
        product_reg    <= product_next;
        out_signed_reg <= sgn_reg[NS-1];
      end
    end
  end
endmodule
